// File: rtl/mem_arb_defs.sv
// rtl/mem_arb_defs.sv - shared encodings for the unified memory arbiter
// Contents:
//   state_t : arbiter FSM states (ST_IDLE, ST_ISSUE, ST_WAIT)
//   REQ_IF / REQ_D : requester ids stored with the latched command
//   BE_ALL : byte-enable value used for every read
package mem_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic       REQ_IF = 1'b0;
  localparam logic       REQ_D  = 1'b1;
  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/arb_priority_sel.sv
// rtl/arb_priority_sel.sv - data-first winner pick with a fetch anti-starvation streak counter
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   arb_en   : arbitration allowed this cycle (arbiter idle, not in reset)
//   if_req   : fetch request level
//   d_req    : data request level
//   if_gnt   : fetch wins this cycle (combinational)
//   d_gnt    : data wins this cycle (combinational)
module arb_priority_sel #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  // Counts data grants that were given while fetch was also waiting.
  logic [SW-1:0] streak;
  logic          fetch_turn;

  // Fetch wins when it is alone, or when data has already taken its full streak.
  assign fetch_turn = if_req && (!d_req || (streak == SW'(MAX_D_STREAK)));
  assign if_gnt     = arb_en && fetch_turn;
  assign d_gnt      = arb_en && d_req && !fetch_turn;

  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (if_gnt) begin
      streak <= '0;
    end else if (d_gnt) begin
      // Only contested data grants build the streak; an uncontested one clears it.
      streak <= if_req ? streak + SW'(1) : '0;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port unified memory shared by fetch and load/store ports
// Ports:
//   clk, rst                        : clock and synchronous active-high reset
//   if_req/if_addr -> if_gnt        : fetch request, accepted combinationally in IDLE
//   if_valid/if_rdata               : fetch response pulse and registered word
//   d_req/d_we/d_be/d_addr/d_wdata  : load/store request -> d_gnt
//   d_valid/d_rdata                 : load data or store completion (rdata 0 on store)
//   mem_en/we/be/addr/wdata         : one-cycle memory command, zero outside ISSUE
//   mem_rdata                       : read data, valid MEM_LAT cycles after mem_en
//   busy                            : a transaction is in flight (drives core stall)
module unified_mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int ADDR_W       = 8,
  parameter int MEM_LAT      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int LW = $clog2(MEM_LAT + 1);

  state_t            state, state_next;
  logic [LW-1:0]     lat_cnt;
  logic              lat_done;
  logic              arb_en;
  logic              issue;

  logic              cmd_id;
  logic              cmd_we;
  logic [3:0]        cmd_be;
  logic [ADDR_W-3:0] cmd_addr;
  logic [31:0]       cmd_wdata;

  // Byte-offset bits are deliberately dropped; the memory is word-addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  // Gating with rst keeps gnt low during reset even though state is already IDLE.
  assign arb_en   = (state == ST_IDLE) && !rst;
  assign lat_done = (lat_cnt == LW'(MEM_LAT));
  assign issue    = (state == ST_ISSUE);
  assign busy     = (state != ST_IDLE);

  arb_priority_sel #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_sel (
    .clk   (clk),
    .rst   (rst),
    .arb_en(arb_en),
    .if_req(if_req),
    .d_req (d_req),
    .if_gnt(if_gnt),
    .d_gnt (d_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (if_gnt || d_gnt) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (lat_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // lat_cnt reads 1 on the first WAIT cycle, i.e. one cycle after mem_en.
  always_ff @(posedge clk) begin
    if (rst)                            lat_cnt <= '0;
    else if (issue)                     lat_cnt <= LW'(1);
    else if (state == ST_WAIT && !lat_done) lat_cnt <= lat_cnt + LW'(1);
    else                                lat_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_id    <= REQ_IF;
      cmd_we    <= 1'b0;
      cmd_be    <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (d_gnt) begin
      cmd_id    <= REQ_D;
      cmd_we    <= d_we;
      cmd_be    <= d_we ? d_be : BE_ALL;
      cmd_addr  <= d_addr[ADDR_W-1:2];
      cmd_wdata <= d_wdata;
    end else if (if_gnt) begin
      cmd_id    <= REQ_IF;
      cmd_we    <= 1'b0;
      cmd_be    <= BE_ALL;
      cmd_addr  <= if_addr[ADDR_W-1:2];
      cmd_wdata <= '0;
    end
  end

  assign mem_en    = issue;
  assign mem_we    = issue && cmd_we;
  assign mem_be    = issue ? cmd_be    : '0;
  assign mem_addr  = issue ? cmd_addr  : '0;
  assign mem_wdata = issue ? cmd_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (state == ST_WAIT && lat_done) begin
        if (cmd_id == REQ_D) begin
          d_valid <= 1'b1;
          d_rdata <= cmd_we ? 32'h0 : mem_rdata;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
